// File: rtl/mem_arbiter_if.sv
// Request/response bundle for the two RAM requesters plus the byte-wide RAM port.
// master = CPU side (fetch + data requesters, RAM model), slave = arbiter.
interface mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int MAX_B  = 8
);
  logic                 i_req;
  logic [ADDR_W-1:0]    i_addr;
  logic [1:0]           i_size;
  logic                 i_ack;
  logic [8*MAX_B-1:0]   i_rdata;

  logic                 d_req;
  logic                 d_we;
  logic [ADDR_W-1:0]    d_addr;
  logic [1:0]           d_size;
  logic [8*MAX_B-1:0]   d_wdata;
  logic                 d_ack;
  logic [8*MAX_B-1:0]   d_rdata;

  logic                 mem_load;
  logic [ADDR_W-1:0]    mem_addr;
  logic [7:0]           mem_d;
  logic [7:0]           mem_q;
  logic                 busy;

  modport master (
    output i_req, i_addr, i_size, d_req, d_we, d_addr, d_size, d_wdata, mem_q,
    input  i_ack, i_rdata, d_ack, d_rdata, mem_load, mem_addr, mem_d, busy
  );

  modport slave (
    input  i_req, i_addr, i_size, d_req, d_we, d_addr, d_size, d_wdata, mem_q,
    output i_ack, i_rdata, d_ack, d_rdata, mem_load, mem_addr, mem_d, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sequencing a byte-wide RAM for fetch (I) and data (D) requesters.
// Latency 2**size+1 cycles from grant to ack; requests are held off (req stays high) while busy.
module mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int MAX_B  = 8
) (
  input logic          clk,
  input logic          rst_n,
  mem_arbiter_if.slave bus
);
  localparam int IDX_W = (MAX_B > 1) ? $clog2(MAX_B) : 1;
  localparam int DW    = 8 * MAX_B;

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  state_t            state;
  logic              sel_d;
  logic              last_d;
  logic              we;
  logic [ADDR_W-1:0] base;
  logic [1:0]        size;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  last_idx;
  logic [DW-1:0]     wdata;
  logic              grant_i;
  logic              grant_d;

  // D wins only when I is idle or I was served last.
  always_comb begin
    grant_d  = bus.d_req && (!bus.i_req || !last_d);
    grant_i  = bus.i_req && !grant_d;
    last_idx = IDX_W'((1 << size) - 1);
  end

  always_comb begin
    bus.mem_load = 1'b0;
    bus.mem_addr = '0;
    bus.mem_d    = '0;
    bus.busy     = (state != IDLE);
    if (state == XFER) begin
      bus.mem_addr = base + ADDR_W'(idx);
      if (we) begin
        bus.mem_load = 1'b1;
        bus.mem_d    = wdata[8*idx +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      sel_d       <= 1'b0;
      last_d      <= 1'b1;
      we          <= 1'b0;
      base        <= '0;
      size        <= '0;
      idx         <= '0;
      wdata       <= '0;
      bus.i_ack   <= 1'b0;
      bus.d_ack   <= 1'b0;
      bus.i_rdata <= '0;
      bus.d_rdata <= '0;
    end else begin
      bus.i_ack <= 1'b0;
      bus.d_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_i || grant_d) begin
            sel_d  <= grant_d;
            last_d <= grant_d;
            idx    <= '0;
            state  <= XFER;
            if (grant_d) begin
              base        <= bus.d_addr;
              size        <= bus.d_size;
              we          <= bus.d_we;
              wdata       <= bus.d_wdata;
              bus.d_rdata <= '0;
            end else begin
              base        <= bus.i_addr;
              size        <= bus.i_size;
              we          <= 1'b0;
              wdata       <= '0;
              bus.i_rdata <= '0;
            end
          end
        end
        XFER: begin
          if (!we) begin
            if (sel_d) bus.d_rdata[8*idx +: 8] <= bus.mem_q;
            else       bus.i_rdata[8*idx +: 8] <= bus.mem_q;
          end
          idx <= idx + 1'b1;
          if (idx == last_idx) begin
            state <= DONE;
            if (sel_d) bus.d_ack <= 1'b1;
            else       bus.i_ack <= 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: byte RAM model, transaction-level reference model with per-cycle compare,
// and directed scenarios with literal expectations.
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(16), .MAX_B(8)) bus ();

  mem_arbiter #(.ADDR_W(16), .MAX_B(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;
  int d_ack_cnt = 0;
  int ack_log[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // RAM with a preload backdoor used only while the arbiter is idle.
  logic [7:0]  ram [0:65535];
  logic        pl_en;
  logic [15:0] pl_addr;
  logic [7:0]  pl_dat;

  always @(posedge clk) begin
    if (bus.mem_load) ram[bus.mem_addr] <= bus.mem_d;
    else if (pl_en)   ram[pl_addr] <= pl_dat;
  end
  assign bus.mem_q = ram[bus.mem_addr];

  // Reference model: whole transactions, N transfer cycles then one ack cycle.
  logic [7:0]  ref_mem [0:65535];
  logic        m_act, m_port_d, m_we, m_last_d;
  logic [15:0] m_base;
  logic [63:0] m_wd, m_exp, m_i_rd, m_d_rd;
  int          m_t, m_n;

  function automatic logic [63:0] ref_read(input logic [15:0] a, input logic [1:0] s);
    logic [63:0] r;
    r = '0;
    for (int k = 0; k < (1 << s); k++) r[8*k +: 8] = ref_mem[16'(a + 16'(k))];
    return r;
  endfunction

  wire        g_d    = (bus.d_req && !bus.i_req) || (bus.d_req && bus.i_req && !m_last_d);
  wire [15:0] g_base = g_d ? bus.d_addr : bus.i_addr;
  wire [1:0]  g_size = g_d ? bus.d_size : bus.i_size;
  wire        g_we   = g_d && bus.d_we;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_act <= 1'b0; m_port_d <= 1'b0; m_we <= 1'b0; m_last_d <= 1'b1;
      m_base <= '0; m_wd <= '0; m_exp <= '0; m_i_rd <= '0; m_d_rd <= '0;
      m_t <= 0; m_n <= 0;
    end else begin
      if (pl_en) ref_mem[pl_addr] <= pl_dat;
      if (!m_act) begin
        if (bus.i_req || bus.d_req) begin
          m_act <= 1'b1; m_t <= 0; m_n <= 1 << g_size;
          m_port_d <= g_d; m_last_d <= g_d;
          m_base <= g_base; m_we <= g_we; m_wd <= bus.d_wdata;
          m_exp <= g_we ? 64'h0 : ref_read(g_base, g_size);
          if (g_d) m_d_rd <= '0;
          else     m_i_rd <= '0;
        end
      end else if (m_t < m_n) begin
        if (m_we) ref_mem[16'(m_base + 16'(m_t))] <= m_wd[8*m_t +: 8];
        m_t <= m_t + 1;
        if (m_t == m_n - 1) begin
          if (m_port_d) m_d_rd <= m_exp;
          else          m_i_rd <= m_exp;
        end
      end else begin
        m_act <= 1'b0;
      end
    end
  end

  wire        e_xfer = m_act && (m_t < m_n);
  wire        e_load = e_xfer && m_we;
  wire [15:0] e_addr = e_xfer ? 16'(m_base + 16'(m_t)) : 16'h0;
  wire [7:0]  e_d    = m_wd[8*m_t +: 8];
  wire        e_iack = m_act && (m_t == m_n) && !m_port_d;
  wire        e_dack = m_act && (m_t == m_n) && m_port_d;

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", bus.busy, m_act);
      check("i_ack", bus.i_ack, e_iack);
      check("d_ack", bus.d_ack, e_dack);
      check("mem_load", bus.mem_load, e_load);
      check("mem_addr", bus.mem_addr, e_addr);
      if (e_load) check("mem_d", bus.mem_d, e_d);
      if (!(e_xfer && !m_port_d)) check("i_rdata", bus.i_rdata, m_i_rd);
      if (!(e_xfer && m_port_d))  check("d_rdata", bus.d_rdata, m_d_rd);
      if (bus.i_ack) ack_log.push_back(0);
      if (bus.d_ack) begin
        ack_log.push_back(1);
        d_ack_cnt++;
      end
    end
  end

  task automatic preload(input logic [15:0] a, input logic [7:0] v);
    pl_addr = a; pl_dat = v; pl_en = 1'b1;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  task automatic wait_ack(input bit is_d, output int cyc);
    bit got;
    got = 1'b0;
    cyc = 0;
    while (!got && cyc < 40) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (is_d ? bus.d_ack : bus.i_ack) got = 1'b1;
    end
    check(is_d ? "d_ack_timeout" : "i_ack_timeout", got, 1);
  endtask

  task automatic run_i(input logic [15:0] a, input logic [1:0] s, input int n, output int cyc);
    for (int k = 0; k < n; k++) begin
      bus.i_addr = a + 16'(k); bus.i_size = s; bus.i_req = 1'b1;
      wait_ack(1'b0, cyc);
      @(posedge clk); #1;
    end
    bus.i_req = 1'b0;
  endtask

  task automatic run_d(input logic w, input logic [15:0] a, input logic [1:0] s,
                       input logic [63:0] wd, input int n, output int cyc);
    for (int k = 0; k < n; k++) begin
      bus.d_we = w; bus.d_addr = a + 16'(k); bus.d_size = s; bus.d_wdata = wd; bus.d_req = 1'b1;
      wait_ack(1'b1, cyc);
      @(posedge clk); #1;
    end
    bus.d_req = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc, c1, c2, acks_before;
    bus.i_req = 0; bus.i_addr = 0; bus.i_size = 0;
    bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0; bus.d_size = 0; bus.d_wdata = 0;
    pl_en = 0; pl_addr = 0; pl_dat = 0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", bus.busy, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_i_rdata", bus.i_rdata, 0);
    @(negedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;

    preload(16'h0000, 8'h22);
    preload(16'h0001, 8'h49);
    for (int a = 2; a <= 8; a++) preload(16'(a), 8'h00);
    for (int a = 16'h200; a <= 16'h207; a++) preload(16'(a), 8'h00);
    preload(16'h0300, 8'hA5);
    preload(16'h0400, 8'h5A);

    // 8-byte fetch
    run_i(16'h0000, 2'd3, 1, cyc);
    check("t1_latency", cyc, 9);
    check("t1_i_rdata", bus.i_rdata, 64'h0000_0000_0000_4922);

    // 4-byte write then read back
    run_d(1'b1, 16'h0100, 2'd2, 64'hDEADBEEF, 1, cyc);
    check("t2_latency", cyc, 5);
    check("t2_ram100", ram[16'h0100], 8'hEF);
    check("t2_ram103", ram[16'h0103], 8'hDE);
    run_d(1'b0, 16'h0100, 2'd2, 64'h0, 1, cyc);
    check("t2_d_rdata", bus.d_rdata, 64'hDEADBEEF);

    // contention: both held for two transfers each
    ack_log.delete();
    fork
      run_i(16'h0000, 2'd0, 2, c1);
      run_d(1'b0, 16'h0100, 2'd0, 64'h0, 2, c2);
    join
    check("t3_ack_count", ack_log.size(), 4);
    if (ack_log.size() == 4) begin
      check("t3_order0", ack_log[0], 0);
      check("t3_order1", ack_log[1], 1);
      check("t3_order2", ack_log[2], 0);
      check("t3_order3", ack_log[3], 1);
    end
    check("t3_i_rdata", bus.i_rdata, 64'h49);
    check("t3_d_rdata", bus.d_rdata, 64'hBE);

    // address wrap
    run_d(1'b1, 16'hFFFE, 2'd2, 64'h11223344, 1, cyc);
    check("t4_ramFFFE", ram[16'hFFFE], 8'h44);
    check("t4_ramFFFF", ram[16'hFFFF], 8'h33);
    check("t4_ram0000", ram[16'h0000], 8'h22);
    check("t4_ram0001", ram[16'h0001], 8'h11);
    run_d(1'b0, 16'hFFFE, 2'd2, 64'h0, 1, cyc);
    check("t4_d_rdata", bus.d_rdata, 64'h11223344);

    // reset during an 8-byte write, after three bytes have landed
    acks_before = d_ack_cnt;
    bus.d_we = 1; bus.d_addr = 16'h0200; bus.d_size = 2'd3;
    bus.d_wdata = 64'h0807060504030201; bus.d_req = 1;
    repeat (4) @(posedge clk);
    #1 bus.d_req = 0;
    @(negedge clk);
    check("t5_mid_load", bus.mem_load, 1);
    check("t5_mid_addr", bus.mem_addr, 16'h0203);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_load", bus.mem_load, 0);
    check("t5_rst_busy", bus.busy, 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("t5_no_ack", d_ack_cnt - acks_before, 0);
    check("t5_ram202", ram[16'h0202], 8'h03);
    check("t5_ram203", ram[16'h0203], 8'h00);
    check("t5_ram207", ram[16'h0207], 8'h00);
    run_d(1'b0, 16'h0200, 2'd3, 64'h0, 1, cyc);
    check("t5_latency", cyc, 9);
    check("t5_d_rdata", bus.d_rdata, 64'h0000_0000_0003_0201);

    // fetch address changes after grant
    bus.i_addr = 16'h0300; bus.i_size = 2'd0; bus.i_req = 1;
    @(posedge clk); #1;
    bus.i_addr = 16'h0400;
    wait_ack(1'b0, cyc);
    @(posedge clk); #1;
    bus.i_req = 0;
    check("t6_i_rdata", bus.i_rdata, 64'hA5);

    repeat (3) @(posedge clk);
    #1;
    check("end_idle", bus.busy, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
